ifu_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the pipelined MIPS core.
- Owns the PC register and drives the word index into the asynchronous-read instruction memory, which is 4096 words based at 0x0000_3000.
- Captures the returned word into the IF/ID pipeline register.
- Applies hazard stalls and branch/jump redirects with one architectural delay slot, and traps fetches from misaligned or out-of-range addresses.

---
 rtl/ifu_fetch_ctrl.sv | 112 +++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction-fetch sequencer. Owns the fetch PC, indexes the
//   asynchronous-read IM, loads the IF/ID register, applies hazard stalls and
//   branch/jump redirects (one delay slot) and traps bad fetch addresses.
// Latency: the word at pc is on d_instr one edge later; stall freezes pc and IF/ID.
// Optional build: define IFU_PERF_CNT_EN to add fetch_cnt / stall_cnt outputs.
// Ports: clk, reset (sync, active-high), stall, redirect_valid/redirect_pc in;
//   im_addr out / im_rdata in (IM); pc, d_instr, d_pc, fault, fault_pc out.
module ifu_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096,
  parameter int          AW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [AW-1:0] im_addr,
  input  logic [31:0]   im_rdata,
  output logic [31:0]   pc,
  output logic [31:0]   d_instr,
  output logic [31:0]   d_pc,
  output logic          fault,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   stall_cnt,
`endif
  output logic [31:0]   fault_pc
);

  typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;

  // Upper bound kept at 33 bits so a base near the top of the address space
  // cannot wrap the limit back to a small value.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

  state_t      state, state_nxt;
  logic        bad;
  logic [31:0] pc_seq;

  assign bad     = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_LIMIT);
  assign pc_seq  = pc + 32'd4;
  // Driven from the formula even for bad addresses; the data is then discarded.
  assign im_addr = AW'((pc - IM_BASE) >> 2);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  // Next-state logic: a redirect always wins over the address trap.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (!stall && !redirect_valid && bad) state_nxt = S_FAULT;
      S_FAULT: if (!stall && redirect_valid)         state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    fault = (state == S_FAULT);
  end

  // PC and IF/ID datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= PC_RESET;
      d_instr  <= '0;
      d_pc     <= PC_RESET;
      fault_pc <= '0;
    end else if (!stall) begin
      d_pc <= pc;
      if (state == S_RUN) begin
        if (redirect_valid) begin
          // Delay slot: issue the current word (nop if its address is bad).
          d_instr <= bad ? 32'd0 : im_rdata;
          pc      <= redirect_pc;
        end else if (bad) begin
          d_instr  <= '0;
          fault_pc <= pc;
        end else begin
          d_instr <= im_rdata;
          pc      <= pc_seq;
        end
      end else begin
        // Parked in FAULT: feed nops until a redirect points somewhere new.
        d_instr <= '0;
        if (redirect_valid) pc <= redirect_pc;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic fetch_load;
  assign fetch_load = !stall && (state == S_RUN) && !bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_load) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall)      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed bench for ifu_fetch_ctrl with a behavioural
//   asynchronous-read IM holding 32'hA000_0000 + index in every word.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [11:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] pc, d_instr, d_pc, fault_pc;
  logic        fault;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  logic [31:0] mem [4096];
  int checks = 0;
  int failures = 0;

  assign im_rdata = mem[im_addr];

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_addr(im_addr), .im_rdata(im_rdata),
    .pc(pc), .d_instr(d_instr), .d_pc(d_pc), .fault(fault),
`ifdef IFU_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
    .fault_pc(fault_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_3100;
    reset = 1'b1; tick(); reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    checks++; if (pc !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
    checks++; if (d_instr !== 32'h0) begin failures++; $display("FAIL reset_d_instr got=%h exp=0", d_instr); end
    checks++; if (d_pc !== 32'h3000) begin failures++; $display("FAIL reset_d_pc got=%h exp=%h", d_pc, 32'h3000); end
    checks++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin failures++; $display("FAIL reset_fault got=%b/%h exp=0/0", fault, fault_pc); end
    checks++; if (im_addr !== 12'h000) begin failures++; $display("FAIL reset_im_addr got=%h exp=000", im_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc, exp_instr;
    reset_dut();
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'h3000 + 32'(4 * i);
      exp_instr = 32'hA000_0000 + 32'(i - 1);
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc); end
      checks++; if (d_instr !== exp_instr) begin failures++; $display("FAIL seq_d_instr[%0d] got=%h exp=%h", i, d_instr, exp_instr); end
      checks++; if (d_pc !== exp_pc - 32'd4) begin failures++; $display("FAIL seq_d_pc[%0d] got=%h exp=%h", i, d_pc, exp_pc - 32'd4); end
    end
    checks++; if (im_addr !== 12'h003) begin failures++; $display("FAIL seq_im_addr got=%h exp=003", im_addr); end
  endtask

  task automatic test_stall();
    reset_dut();
    tick(); tick();   // pc=3008, d_instr=IM[1]
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'h3008 || d_instr !== 32'hA000_0001 || d_pc !== 32'h3004) begin
        failures++; $display("FAIL stall_hold[%0d] got pc=%h instr=%h dpc=%h exp 3008/a0000001/3004", i, pc, d_instr, d_pc);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h300C || d_instr !== 32'hA000_0002 || d_pc !== 32'h3008) begin
      failures++; $display("FAIL stall_resume1 got pc=%h instr=%h dpc=%h exp 300c/a0000002/3008", pc, d_instr, d_pc);
    end
    tick();
    checks++; if (pc !== 32'h3010 || d_instr !== 32'hA000_0003 || d_pc !== 32'h300C) begin
      failures++; $display("FAIL stall_resume2 got pc=%h instr=%h dpc=%h exp 3010/a0000003/300c", pc, d_instr, d_pc);
    end
  endtask

  task automatic test_redirect();
    reset_dut();
    tick();           // pc=3004
    redirect_valid = 1'b1; redirect_pc = 32'h3040; stall = 1'b1;
    tick();
    checks++; if (pc !== 32'h3004 || d_instr !== 32'hA000_0000) begin
      failures++; $display("FAIL redir_stalled got pc=%h instr=%h exp 3004/a0000000", pc, d_instr);
    end
    stall = 1'b0;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc !== 32'h3040 || d_instr !== 32'hA000_0001 || d_pc !== 32'h3004) begin
      failures++; $display("FAIL redir_delay_slot got pc=%h instr=%h dpc=%h exp 3040/a0000001/3004", pc, d_instr, d_pc);
    end
    tick();
    checks++; if (pc !== 32'h3044 || d_instr !== 32'hA000_0010 || d_pc !== 32'h3040) begin
      failures++; $display("FAIL redir_target got pc=%h instr=%h dpc=%h exp 3044/a0000010/3040", pc, d_instr, d_pc);
    end
  endtask

  task automatic test_fault_range();
    reset_dut();
    redirect_valid = 1'b1; redirect_pc = 32'h7000;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc !== 32'h7000 || fault !== 1'b0) begin failures++; $display("FAIL range_redir got pc=%h fault=%b exp 7000/0", pc, fault); end
    tick();
    checks++; if (fault !== 1'b1 || fault_pc !== 32'h7000) begin failures++; $display("FAIL range_fault got fault=%b fpc=%h exp 1/7000", fault, fault_pc); end
    checks++; if (d_instr !== 32'h0 || pc !== 32'h7000 || d_pc !== 32'h7000) begin
      failures++; $display("FAIL range_nop got instr=%h pc=%h dpc=%h exp 0/7000/7000", d_instr, pc, d_pc);
    end
    checks++; if (im_addr !== 12'h000) begin failures++; $display("FAIL range_im_addr got=%h exp=000", im_addr); end
    tick();
    checks++; if (fault !== 1'b1 || pc !== 32'h7000) begin failures++; $display("FAIL range_hold got fault=%b pc=%h exp 1/7000", fault, pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b0 || pc !== 32'h3000 || d_instr !== 32'h0) begin
      failures++; $display("FAIL range_exit got fault=%b pc=%h instr=%h exp 0/3000/0", fault, pc, d_instr);
    end
    tick();
    checks++; if (d_instr !== 32'hA000_0000 || pc !== 32'h3004 || fault_pc !== 32'h7000) begin
      failures++; $display("FAIL range_refetch got instr=%h pc=%h fpc=%h exp a0000000/3004/7000", d_instr, pc, fault_pc);
    end
  endtask

  task automatic test_redirect_over_bad();
    reset_dut();
    redirect_valid = 1'b1; redirect_pc = 32'h7000;
    tick();            // pc=7000 (bad) and another redirect already pending
    redirect_pc = 32'h3010;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b0 || fault_pc !== 32'h0 || d_instr !== 32'h0 || d_pc !== 32'h7000 || pc !== 32'h3010) begin
      failures++; $display("FAIL redir_over_bad got fault=%b fpc=%h instr=%h dpc=%h pc=%h exp 0/0/0/7000/3010", fault, fault_pc, d_instr, d_pc, pc);
    end
    tick();
    checks++; if (d_instr !== 32'hA000_0004 || fault !== 1'b0) begin
      failures++; $display("FAIL redir_over_bad_next got instr=%h fault=%b exp a0000004/0", d_instr, fault);
    end
  endtask

  task automatic test_misaligned_reset();
    reset_dut();
    redirect_valid = 1'b1; redirect_pc = 32'h3002;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (fault !== 1'b1 || fault_pc !== 32'h3002 || pc !== 32'h3002) begin
      failures++; $display("FAIL misalign_fault got fault=%b fpc=%h pc=%h exp 1/3002/3002", fault, fault_pc, pc);
    end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3100;
    tick();
    checks++; if (fault !== 1'b1 || pc !== 32'h3002) begin failures++; $display("FAIL fault_stall got fault=%b pc=%h exp 1/3002", fault, pc); end
    stall = 1'b0; redirect_pc = 32'h8000;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b0 || pc !== 32'h8000) begin failures++; $display("FAIL fault_to_bad got fault=%b pc=%h exp 0/8000", fault, pc); end
    tick();
    checks++; if (fault !== 1'b1 || fault_pc !== 32'h8000) begin failures++; $display("FAIL refault got fault=%b fpc=%h exp 1/8000", fault, fault_pc); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (fault !== 1'b0 || pc !== 32'h3000 || d_instr !== 32'h0 || fault_pc !== 32'h0) begin
      failures++; $display("FAIL fault_reset got fault=%b pc=%h instr=%h fpc=%h exp 0/3000/0/0", fault, pc, d_instr, fault_pc);
    end
    tick();
    checks++; if (fault !== 1'b0 || d_instr !== 32'hA000_0000) begin failures++; $display("FAIL post_reset got fault=%b instr=%h exp 0/a0000000", fault, d_instr); end
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset_dut();
    checks++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin failures++; $display("FAIL perf_reset got=%0d/%0d exp 0/0", fetch_cnt, stall_cnt); end
    for (int i = 0; i < 10; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stall = 1'b0;
    checks++; if (fetch_cnt !== 32'd10 || stall_cnt !== 32'd3) begin failures++; $display("FAIL perf_counts got=%0d/%0d exp 10/3", fetch_cnt, stall_cnt); end
    redirect_valid = 1'b1; redirect_pc = 32'h7000;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    checks++; if (fetch_cnt !== 32'd11 || fault !== 1'b1) begin failures++; $display("FAIL perf_fault got=%0d fault=%b exp 11/1", fetch_cnt, fault); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i);
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault_range();
    test_redirect_over_bad();
    test_misaligned_reset();
`ifdef IFU_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
